// File: rtl/fft_phase_sync_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_phase_sync_tracker_pkg
//  Description : Shared FFT definitions: tracker state encoding, default
//                sequence constants and a counter width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package fft_phase_sync_tracker_pkg;

    // Defaults shared with the FFT sequencing counter
    localparam int c_FFT_N     = 5;
    localparam int c_FFT_WIDTH = 3;

    // Tracker acquisition states
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_t;

    // Bits needed to hold every value 0..max_val (never less than one bit)
    function automatic int width_for(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_phase_sync_tracker_phase_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : fft_phase_ctr
//  Description : Mod-N phase counter with synchronous clear-to-0 and
//                load-to-1 controls, plus a wrap flag at N-1.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_phase_ctr
    import fft_phase_sync_tracker_pkg::*;
#(
    parameter int N     = c_FFT_N,
    parameter int WIDTH = c_FFT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_clear,
    input  logic             i_load_one,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(N - 1);
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_cnt;

    // Count modulo N; clear wins over load-one, both over counting
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load_one) begin
            r_cnt <= c_ONE;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_wrap = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/fft_phase_sync_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : fft_phase_sync_tracker
//  Description : Recovers the FFT sequence phase from a once-per-sequence
//                strobe. Hunts, verifies spacing, locks and then flywheels,
//                flagging missing and misplaced strobes while locked.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_phase_sync_tracker
    import fft_phase_sync_tracker_pkg::*;
#(
    parameter int N          = c_FFT_N,
    parameter int WIDTH      = c_FFT_WIDTH,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             strobe_in,
    output logic [WIDTH-1:0] phase,
    output logic             locked,
    output logic             frame_o,
    output logic             miss_err,
    output logic             slip_err
);

    localparam int c_GOOD_W = width_for(LOCK_CNT);
    localparam int c_ERR_W  = width_for(UNLOCK_CNT);

    localparam logic [c_GOOD_W-1:0] c_GOOD_ONE  = c_GOOD_W'(1);
    localparam logic [c_GOOD_W-1:0] c_GOOD_MAX  = c_GOOD_W'(LOCK_CNT);
    localparam logic [c_GOOD_W-1:0] c_GOOD_LAST = c_GOOD_W'(LOCK_CNT - 1);
    localparam logic [c_ERR_W-1:0]  c_ERR_LAST  = c_ERR_W'(UNLOCK_CNT - 1);

    sync_state_t         r_state;
    sync_state_t         w_state_nxt;
    logic [c_GOOD_W-1:0] r_good_cnt;
    logic [c_GOOD_W-1:0] w_good_nxt;
    logic [c_ERR_W-1:0]  r_err_cnt;
    logic [c_ERR_W-1:0]  w_err_nxt;
    logic                r_locked;
    logic                r_miss;
    logic                r_slip;
    logic                w_miss_nxt;
    logic                w_slip_nxt;
    logic                w_clear;
    logic                w_load_one;
    logic                w_slot;
    logic                w_unused_wrap;

    // Phase counter; the FSM only ever clears it or realigns it to 1
    fft_phase_ctr #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_phase_ctr (
        .clk        (clk),
        .rstn       (rstn),
        .i_clear    (w_clear),
        .i_load_one (w_load_one),
        .o_cnt      (phase),
        .o_wrap     (w_unused_wrap)
    );

    // The expected strobe slot is the cycle where the recovered phase is 0
    assign w_slot = (phase == '0);

    // Next-state, counter control and error decode
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_err_nxt   = r_err_cnt;
        w_miss_nxt  = 1'b0;
        w_slip_nxt  = 1'b0;
        w_clear     = 1'b0;
        w_load_one  = 1'b0;
        case (r_state)
            HUNT: begin
                w_good_nxt = '0;
                w_err_nxt  = '0;
                if (strobe_in) begin
                    w_load_one  = 1'b1;
                    w_good_nxt  = c_GOOD_ONE;
                    w_state_nxt = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                end else begin
                    w_clear = 1'b1;
                end
            end
            VERIFY: begin
                if (w_slot && strobe_in) begin
                    if (r_good_cnt >= c_GOOD_LAST) begin
                        w_good_nxt  = c_GOOD_MAX;
                        w_state_nxt = LOCKED;
                    end else begin
                        w_good_nxt = r_good_cnt + 1'b1;
                    end
                end else if (w_slot) begin
                    // Spacing broken: start hunting from scratch
                    w_clear     = 1'b1;
                    w_good_nxt  = '0;
                    w_state_nxt = HUNT;
                end else if (strobe_in) begin
                    // Early/late strobe becomes the new reference point
                    w_load_one = 1'b1;
                    w_good_nxt = c_GOOD_ONE;
                end
            end
            LOCKED: begin
                // Flywheel: phase never realigns here, errors only counted
                w_miss_nxt = w_slot && !strobe_in;
                w_slip_nxt = !w_slot && strobe_in;
                if (w_slot && strobe_in) begin
                    w_err_nxt = '0;
                end else if (w_miss_nxt || w_slip_nxt) begin
                    if (r_err_cnt >= c_ERR_LAST) begin
                        w_clear     = 1'b1;
                        w_err_nxt   = '0;
                        w_good_nxt  = '0;
                        w_state_nxt = HUNT;
                    end else begin
                        w_err_nxt = r_err_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_clear     = 1'b1;
                w_good_nxt  = '0;
                w_err_nxt   = '0;
                w_state_nxt = HUNT;
            end
        endcase
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= HUNT;
            r_good_cnt <= '0;
            r_err_cnt  <= '0;
            r_locked   <= 1'b0;
            r_miss     <= 1'b0;
            r_slip     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
            r_err_cnt  <= w_err_nxt;
            r_locked   <= (w_state_nxt == LOCKED);
            r_miss     <= w_miss_nxt;
            r_slip     <= w_slip_nxt;
        end
    end

    assign locked   = r_locked;
    assign miss_err = r_miss;
    assign slip_err = r_slip;
    assign frame_o  = r_locked && (phase == '0);

endmodule
`default_nettype wire

// File: tb/tb_fft_phase_sync_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_phase_sync_tracker
//  Description : Self-checking bench for fft_phase_sync_tracker: directed
//                acquisition/miss/slip/unlock/realign scenarios followed by a
//                randomized strobe source with drops, extras, re-phasing and
//                resets, all compared against a timeline-based reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_phase_sync_tracker;

    localparam int N          = 5;
    localparam int WIDTH      = 3;
    localparam int LOCK_CNT   = 3;
    localparam int UNLOCK_CNT = 2;

    localparam int M_HUNT   = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             strobe_in = 1'b0;
    logic [WIDTH-1:0] phase;
    logic             locked;
    logic             frame_o;
    logic             miss_err;
    logic             slip_err;

    fft_phase_sync_tracker #(
        .N          (N),
        .WIDTH      (WIDTH),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .strobe_in (strobe_in),
        .phase     (phase),
        .locked    (locked),
        .frame_o   (frame_o),
        .miss_err  (miss_err),
        .slip_err  (slip_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference: the phase is the distance (mod N) from the last alignment
    // strobe, measured in clock edges on a global timeline.
    int k        = 0;
    int m_mode   = M_HUNT;
    int m_anchor = 0;
    int m_good   = 0;
    int m_err    = 0;
    int m_phase  = 0;
    int m_locked = 0;
    int m_frame  = 0;
    int m_miss   = 0;
    int m_slip   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s @edge %0d: got %0d, expected %0d", tag, k, obs, exp);
    endtask

    // Advance the reference by one clock edge with the given inputs
    task automatic model(input bit s, input bit r);
        int p;
        p      = (m_mode == M_HUNT) ? 0 : (k - m_anchor) % N;
        m_miss = 0;
        m_slip = 0;
        if (!r) begin
            m_mode = M_HUNT;
            m_good = 0;
            m_err  = 0;
        end else if (m_mode == M_HUNT) begin
            if (s) begin
                m_anchor = k;
                m_good   = 1;
                m_mode   = (m_good >= LOCK_CNT) ? M_LOCKED : M_VERIFY;
            end
        end else if (m_mode == M_VERIFY) begin
            if (s && p == 0) begin
                m_good++;
                if (m_good >= LOCK_CNT) m_mode = M_LOCKED;
            end else if (s) begin
                m_anchor = k;
                m_good   = 1;
            end else if (p == 0) begin
                m_mode = M_HUNT;
                m_good = 0;
            end
        end else begin
            if (s && p == 0) begin
                m_err = 0;
            end else if (s || p == 0) begin
                if (p == 0) m_miss = 1;
                else        m_slip = 1;
                m_err++;
                if (m_err >= UNLOCK_CNT) begin
                    m_mode = M_HUNT;
                    m_err  = 0;
                    m_good = 0;
                end
            end
        end
        m_phase  = (m_mode == M_HUNT) ? 0 : (k + 1 - m_anchor) % N;
        m_locked = (m_mode == M_LOCKED) ? 1 : 0;
        m_frame  = (m_locked == 1 && m_phase == 0) ? 1 : 0;
        k++;
    endtask

    // Drive one cycle, step the reference, then compare after the edge
    task automatic step(input logic s, input logic r);
        strobe_in = s;
        rstn      = r;
        @(posedge clk);
        model(s, r);
        #1;
        check("phase",    int'(phase),    m_phase);
        check("locked",   int'(locked),   m_locked);
        check("frame_o",  int'(frame_o),  m_frame);
        check("miss_err", int'(miss_err), m_miss);
        check("slip_err", int'(slip_err), m_slip);
    endtask

    initial begin
        int src_ph;
        logic s;

        // Reset state
        repeat (3) step(1'b0, 1'b0);
        check("rst_phase",  int'(phase),  0);
        check("rst_locked", int'(locked), 0);

        // Acquisition, single miss at 30, slip at 42, unlock via 55 and 60
        for (int c = 0; c < 66; c++) begin
            s = (c >= 10 && c % 5 == 0 && c != 30 && c != 55 && c != 60) || c == 42;
            step(s, 1'b1);
            if (c == 10) check("acq_phase1",   int'(phase),    1);
            if (c == 20) check("acq_locked",   int'(locked),   1);
            if (c == 24) check("acq_frame",    int'(frame_o),  1);
            if (c == 30) check("miss_pulse",   int'(miss_err), 1);
            if (c == 31) check("miss_single",  int'(miss_err), 0);
            if (c == 35) check("miss_kept",    int'(locked),   1);
            if (c == 42) check("slip_pulse",   int'(slip_err), 1);
            if (c == 42) check("slip_phase",   int'(phase),    3);
            if (c == 60) check("unlock_state", int'(locked),   0);
            if (c == 60) check("unlock_miss",  int'(miss_err), 1);
            if (c == 60) check("unlock_phase", int'(phase),    0);
        end

        // Realign in VERIFY: strobes at 10 and 13, then 18 and 23
        step(1'b0, 1'b0);
        for (int c = 0; c < 30; c++) begin
            s = (c == 10 || c == 13 || c == 18 || c == 23);
            step(s, 1'b1);
            if (c == 13) check("realign_phase", int'(phase),  1);
            if (c == 23) check("realign_lock",  int'(locked), 1);
        end

        // Reset while locked
        step(1'b0, 1'b0);
        check("midrst_locked", int'(locked), 0);
        check("midrst_frame",  int'(frame_o), 0);

        // Randomized source: periodic strobe with drops, extras, re-phasing
        src_ph = int'($urandom_range(N - 1, 0));
        for (int c = 0; c < 4000; c++) begin
            src_ph = (src_ph + 1) % N;
            if ($urandom_range(99, 0) == 0) src_ph = int'($urandom_range(N - 1, 0));
            s = (src_ph == 0);
            if (s && $urandom_range(99, 0) < 6) s = 1'b0;
            else if (!s && $urandom_range(99, 0) < 4) s = 1'b1;
            step(s, ($urandom_range(199, 0) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_phase_sync_tracker.md
Name: fft_phase_sync_tracker

Overview:
Receive-side companion to the FFT sequencing counter. It watches the single-cycle strobe emitted once per mod-N sequence and reconstructs the phase index locally. It declares lock after repeated correctly spaced strobes, then free-runs as a flywheel. While locked it reports missing strobes and slipped (misplaced) strobes. Downstream FFT stages use the recovered phase and frame marker instead of routing the counter bus.

Parameters:
N, 5, sequence length (strobe period in clk cycles); legal range N >= 2
WIDTH, 3, phase width; must satisfy 2**WIDTH >= N
LOCK_CNT, 3, consecutive correctly spaced strobes required to enter LOCKED; >= 1
UNLOCK_CNT, 2, consecutive errors (miss or slip) in LOCKED that force return to HUNT; >= 1

Ports:
clk  in  1  clock; all logic on posedge
rstn  in  1  reset, synchronous, active-low
strobe_in  in  1  one-cycle sequence-start strobe, sampled on posedge clk
phase  out  WIDTH  recovered phase 0..N-1, registered; meaningful only when locked=1
locked  out  1  registered lock indicator
frame_o  out  1  locked && (phase == 0), decoded from registers only
miss_err  out  1  one-cycle registered pulse: expected strobe absent while LOCKED
slip_err  out  1  one-cycle registered pulse: strobe at phase != 0 while LOCKED

Behaviour:
- Reset (rstn=0 at posedge): state=HUNT, phase=0, locked=0, miss_err=0, slip_err=0, good_cnt=0, err_cnt=0. Reset mid-operation aborts the current state and takes effect on that edge.
- Phase counter: increments mod N each cycle (N-1 -> 0) in VERIFY and LOCKED. It is held at 0 in HUNT. "Expected slot" = the cycle in which phase==0 in VERIFY/LOCKED.
- HUNT: if strobe_in=1, then next cycle phase=1, good_cnt=1, and state=VERIFY. If LOCK_CNT=1, state goes directly to LOCKED instead. If strobe_in=0, stay in HUNT.
- VERIFY:
  - Strobe in expected slot: good_cnt+1. When that count reaches LOCK_CNT, go to LOCKED; locked=1 on the same edge.
  - Strobe outside the expected slot: realign. Next phase=1, good_cnt=1, stay in VERIFY.
  - Expected slot with no strobe: go to HUNT; phase=0, good_cnt=0.
  - No error pulses are raised in VERIFY.
- LOCKED (flywheel, never realigns):
  - Strobe in expected slot: err_cnt=0.
  - Expected slot with no strobe: miss_err=1 next cycle, err_cnt+1.
  - Strobe at phase != 0: slip_err=1 next cycle, err_cnt+1. Phase continues unchanged.
  - If err_cnt+1 reaches UNLOCK_CNT: next cycle state=HUNT, locked=0, phase=0, err_cnt=0. The error pulse for that event is still asserted on that cycle.
- Miss and slip are mutually exclusive in any one cycle (slot vs non-slot).
- err_cnt counts consecutive errors only; any on-time strobe clears it.
- Latency: strobe_in to state/phase update is 1 cycle. Error pulses appear 1 cycle after the offending slot.
- Width: phase, good_cnt and err_cnt are sized to cover their maximum values. The counters saturate and do not wrap.

Decomposition:
- Shared FFT package:
  - state enum {HUNT, VERIFY, LOCKED}
  - clog2-based width helper
  - default N/WIDTH constants shared with the sequencing counter
- One sub-module: fft_phase_ctr. It is a mod-N counter with synchronous clear (to 0) and load-one (to 1) inputs and a wrap flag. The tracker FSM instantiates it and drives clear/load.

Test Plan:
- Acquisition (N=5, LOCK_CNT=3), strobes at cycles 10, 15, 20:
  - cycle 11: state VERIFY, phase=1
  - cycle 21: locked=1, phase=1
  - cycle 25: frame_o=1
- Single miss: locked; strobe omitted at cycle 30, resumes at 35:
  - cycle 31: miss_err=1 for exactly one cycle
  - locked stays 1; err_cnt cleared after cycle 35
- Unlock (UNLOCK_CNT=2): strobes omitted at 30 and 35:
  - miss_err pulses at 31 and 36
  - cycle 36: locked=0, phase=0, state HUNT
- Slip: locked; extra strobe at cycle 27 (phase=2), normal strobe at 30:
  - cycle 28: slip_err=1
  - phase sequence unbroken (cycle 28 phase=3)
  - locked stays 1
- Realign in VERIFY: strobes at 10 and 13:
  - cycle 14: phase=1, good_cnt=1
  - further strobes at 18 and 23 → cycle 24: locked=1
- Reset mid-lock: rstn=0 at cycle 40 while locked:
  - cycle 41: phase=0, locked=0, frame_o=0, both error flags 0
  - reacquisition after rstn=1 follows the acquisition timing
